// File: rtl/riscv_core_pkg.sv
// Shared RV64I front-end types and defaults.
// Used by the fetch PC controller and its target mux.
package riscv_core_pkg;

  localparam int ADDRLEN = 64;
  localparam logic [63:0] RESET_VECTOR = 64'h0000_0000_8000_0000;
  localparam int INST_BYTES = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    BUBBLE
  } fetch_pc_state_t;

  typedef enum logic [1:0] {
    SRC_SEQ,
    SRC_BP,
    SRC_MISPRED,
    SRC_TRAP
  } redirect_src_t;

endpackage

// File: rtl/riscv_core_pc_target_mux.sv
// Priority select of the next fetch PC:
// trap > mispredict > taken prediction > sequential.
module riscv_core_pc_target_mux
  import riscv_core_pkg::*;
#(
  parameter int ADDRLEN    = riscv_core_pkg::ADDRLEN,
  parameter int INST_BYTES = riscv_core_pkg::INST_BYTES
) (
  input  logic               trap_valid,
  input  logic [ADDRLEN-1:0] trap_addr,
  input  logic               mispred_valid,
  input  logic [ADDRLEN-1:0] recovered_addr,
  input  logic               bp_take,
  input  logic [ADDRLEN-1:0] bp_addr,
  input  logic               advance,
  input  logic [ADDRLEN-1:0] cur_pc,
  output logic [ADDRLEN-1:0] next_pc,
  output redirect_src_t      src
);

  always_comb begin
    next_pc = cur_pc;
    src     = SRC_SEQ;
    if (trap_valid) begin
      next_pc = trap_addr;
      src     = SRC_TRAP;
    end else if (mispred_valid) begin
      next_pc = recovered_addr;
      src     = SRC_MISPRED;
    end else if (bp_take) begin
      next_pc = bp_addr;
      src     = SRC_BP;
    end else if (advance) begin
      // Wraps modulo 2^ADDRLEN by design.
      next_pc = cur_pc + ADDRLEN'(INST_BYTES);
    end
  end

endmodule

// File: rtl/riscv_core_fetch_pc_ctrl.sv
// Fetch PC register, redirect sequencing and post-flush bubbles.
// Optional RISCV_CORE_FETCH_PC_PERF_CNT_EN adds redirect counters.
module riscv_core_fetch_pc_ctrl
  import riscv_core_pkg::*;
#(
  parameter int ADDRLEN = riscv_core_pkg::ADDRLEN,
  parameter logic [ADDRLEN-1:0] RESET_VECTOR =
    ADDRLEN'(riscv_core_pkg::RESET_VECTOR),
  parameter int INST_BYTES    = riscv_core_pkg::INST_BYTES,
  parameter int FLUSH_BUBBLES = 2
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_trap_valid,
  input  logic [ADDRLEN-1:0] i_trap_addr,
  input  logic               i_mispred_valid,
  input  logic [ADDRLEN-1:0] i_recovered_addr,
  input  logic               i_bp_valid,
  input  logic               i_bp_taken,
  input  logic [ADDRLEN-1:0] i_bp_addr,
  input  logic               i_fetch_ready,
  output logic               o_fetch_valid,
  output logic [ADDRLEN-1:0] o_fetch_pc,
  output logic               o_flush
`ifdef RISCV_CORE_FETCH_PC_PERF_CNT_EN
  ,
  output logic [31:0]        o_redirect_cnt,
  output logic [31:0]        o_bp_redirect_cnt
`endif
);

  localparam logic [3:0] BUBBLES = 4'(FLUSH_BUBBLES);

  fetch_pc_state_t    state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [ADDRLEN-1:0] pc_q;
  logic               flush_q;
  logic [ADDRLEN-1:0] next_pc;
  redirect_src_t      src;
  logic               fire;
  logic               bp_take;
  logic               hard;

  assign o_fetch_valid = (state_q == RUN);
  assign o_fetch_pc    = pc_q;
  assign o_flush       = flush_q;

  assign fire    = o_fetch_valid & i_fetch_ready;
  assign bp_take = fire & i_bp_valid & i_bp_taken;
  assign hard    = (src == SRC_TRAP) || (src == SRC_MISPRED);

  riscv_core_pc_target_mux #(
    .ADDRLEN    (ADDRLEN),
    .INST_BYTES (INST_BYTES)
  ) u_mux (
    .trap_valid     (i_trap_valid),
    .trap_addr      (i_trap_addr),
    .mispred_valid  (i_mispred_valid),
    .recovered_addr (i_recovered_addr),
    .bp_take        (bp_take),
    .bp_addr        (i_bp_addr),
    .advance        (fire),
    .cur_pc         (pc_q),
    .next_pc        (next_pc),
    .src            (src)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (hard) begin
      if (BUBBLES != 4'd0) begin
        state_d = BUBBLE;
        cnt_d   = BUBBLES;
      end else begin
        state_d = RUN;
        cnt_d   = 4'd0;
      end
    end else begin
      unique case (state_q)
        BOOT: state_d = RUN;
        RUN:  state_d = RUN;
        BUBBLE: begin
          if (cnt_q <= 4'd1) begin
            state_d = RUN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q <= BOOT;
      cnt_q   <= 4'd0;
      pc_q    <= RESET_VECTOR;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= next_pc;
      flush_q <= hard;
    end
  end

`ifdef RISCV_CORE_FETCH_PC_PERF_CNT_EN
  logic [31:0] redir_cnt_q;
  logic [31:0] bp_cnt_q;

  assign o_redirect_cnt    = redir_cnt_q;
  assign o_bp_redirect_cnt = bp_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      redir_cnt_q <= 32'd0;
      bp_cnt_q    <= 32'd0;
    end else begin
      if (hard && (redir_cnt_q != 32'hFFFF_FFFF))
        redir_cnt_q <= redir_cnt_q + 32'd1;
      if ((src == SRC_BP) && (bp_cnt_q != 32'hFFFF_FFFF))
        bp_cnt_q <= bp_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_riscv_core_fetch_pc_ctrl.sv
// Randomised + directed bench for the fetch PC controller,
// two instances: FLUSH_BUBBLES=2 and FLUSH_BUBBLES=0.
module tb_riscv_core_fetch_pc_ctrl;

  localparam logic [63:0] RV = 64'h0000_0000_8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn = 1'b0;
  logic        trap = 1'b0;
  logic [63:0] trap_addr = '0;
  logic        misp = 1'b0;
  logic [63:0] rec_addr = '0;
  logic        bpv = 1'b0;
  logic        bpt = 1'b0;
  logic [63:0] bp_addr = '0;
  logic        ready = 1'b1;

  logic        fv[2];
  logic [63:0] pc[2];
  logic        fl[2];
  logic [31:0] rc[2];
  logic [31:0] bc[2];

  riscv_core_fetch_pc_ctrl u_dut0 (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .i_trap_valid     (trap),
    .i_trap_addr      (trap_addr),
    .i_mispred_valid  (misp),
    .i_recovered_addr (rec_addr),
    .i_bp_valid       (bpv),
    .i_bp_taken       (bpt),
    .i_bp_addr        (bp_addr),
    .i_fetch_ready    (ready),
    .o_fetch_valid    (fv[0]),
    .o_fetch_pc       (pc[0]),
    .o_flush          (fl[0])
`ifdef RISCV_CORE_FETCH_PC_PERF_CNT_EN
    ,
    .o_redirect_cnt    (rc[0]),
    .o_bp_redirect_cnt (bc[0])
`endif
  );

  riscv_core_fetch_pc_ctrl #(.FLUSH_BUBBLES(0)) u_dut1 (
    .i_clk            (clk),
    .i_rstn           (rstn),
    .i_trap_valid     (trap),
    .i_trap_addr      (trap_addr),
    .i_mispred_valid  (misp),
    .i_recovered_addr (rec_addr),
    .i_bp_valid       (bpv),
    .i_bp_taken       (bpt),
    .i_bp_addr        (bp_addr),
    .i_fetch_ready    (ready),
    .o_fetch_valid    (fv[1]),
    .o_fetch_pc       (pc[1]),
    .o_flush          (fl[1])
`ifdef RISCV_CORE_FETCH_PC_PERF_CNT_EN
    ,
    .o_redirect_cnt    (rc[1]),
    .o_bp_redirect_cnt (bc[1])
`endif
  );

  // Model: hold = number of cycles (incl. current) fetch stays invalid.
  int          bub[2] = '{2, 0};
  logic [63:0] m_pc[2];
  int          m_hold[2];
  logic        m_flush[2];
  logic [31:0] m_rc[2];
  logic [31:0] m_bc[2];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_update(int k);
    bit fire;
    fire = (m_hold[k] == 0) && ready;
    if (!rstn) begin
      m_pc[k]    = RV;
      m_hold[k]  = 1;
      m_flush[k] = 1'b0;
      m_rc[k]    = '0;
      m_bc[k]    = '0;
    end else if (trap || misp) begin
      m_pc[k]    = trap ? trap_addr : rec_addr;
      m_flush[k] = 1'b1;
      m_hold[k]  = bub[k];
      m_rc[k]    = sat_inc(m_rc[k]);
    end else begin
      m_flush[k] = 1'b0;
      if (fire && bpv && bpt) begin
        m_pc[k] = bp_addr;
        m_bc[k] = sat_inc(m_bc[k]);
      end else if (fire) begin
        m_pc[k] = m_pc[k] + 64'd4;
      end
      if (m_hold[k] > 0) m_hold[k]--;
    end
  endtask

  task automatic step();
    for (int k = 0; k < 2; k++) model_update(k);
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("pc%0d", k), pc[k], m_pc[k]);
      check($sformatf("valid%0d", k), 64'(fv[k]), 64'(m_hold[k] == 0));
      check($sformatf("flush%0d", k), 64'(fl[k]), 64'(m_flush[k]));
`ifdef RISCV_CORE_FETCH_PC_PERF_CNT_EN
      check($sformatf("rcnt%0d", k), 64'(rc[k]), 64'(m_rc[k]));
      check($sformatf("bcnt%0d", k), 64'(bc[k]), 64'(m_bc[k]));
`endif
    end
  endtask

  task automatic idle();
    trap = 1'b0;
    misp = 1'b0;
    bpv  = 1'b0;
    bpt  = 1'b0;
  endtask

  initial begin
    idle();
    rstn  = 1'b0;
    ready = 1'b1;
    step();
    step();
    check("rst_pc", pc[0], RV);
    check("rst_valid", 64'(fv[0]), 64'd0);
    check("rst_flush", 64'(fl[0]), 64'd0);

    rstn = 1'b1;
    step();
    check("boot_pc0", pc[0], 64'h8000_0000);
    check("boot_v0", 64'(fv[0]), 64'd1);
    step();
    check("seq_pc4", pc[0], 64'h8000_0004);
    step();
    check("seq_pc8", pc[0], 64'h8000_0008);

    ready = 1'b0;
    repeat (3) step();
    check("stall_pc", pc[0], 64'h8000_0008);
    check("stall_v", 64'(fv[0]), 64'd1);
    ready = 1'b1;
    step();
    check("unstall_pc", pc[0], 64'h8000_000C);
    step();
    check("pre_bp_pc", pc[0], 64'h8000_0010);

    bpv = 1'b1;
    bpt = 1'b1;
    bp_addr = 64'h8000_0100;
    step();
    idle();
    check("bp_pc", pc[0], 64'h8000_0100);
    check("bp_flush", 64'(fl[0]), 64'd0);
    check("bp_v", 64'(fv[0]), 64'd1);

    trap = 1'b1;
    trap_addr = 64'h1000;
    misp = 1'b1;
    rec_addr = 64'h8000_0040;
    step();
    idle();
    check("tm_pc", pc[0], 64'h1000);
    check("tm_flush", 64'(fl[0]), 64'd1);
    check("tm_v", 64'(fv[0]), 64'd0);
    check("nb_v", 64'(fv[1]), 64'd1);
    step();
    check("tm_flush_once", 64'(fl[0]), 64'd0);
    check("tm_v2", 64'(fv[0]), 64'd0);
    step();
    check("tm_v3", 64'(fv[0]), 64'd1);

    trap = 1'b1;
    step();
    idle();
    step();
    misp = 1'b1;
    rec_addr = 64'h2000;
    step();
    idle();
    check("bub_pc", pc[0], 64'h2000);
    check("bub_flush", 64'(fl[0]), 64'd1);
    step();
    check("bub_v1", 64'(fv[0]), 64'd0);
    step();
    check("bub_v2", 64'(fv[0]), 64'd1);

    rstn = 1'b0;
    trap = 1'b1;
    bpv  = 1'b1;
    bpt  = 1'b1;
    step();
    idle();
    check("mrst_pc", pc[0], RV);
    check("mrst_v", 64'(fv[0]), 64'd0);
    check("mrst_flush", 64'(fl[0]), 64'd0);
    rstn = 1'b1;
    step();

    trap = 1'b1;
    trap_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    step();
    idle();
    step();
    step();
    check("wrap_pre", pc[0], 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check("wrap_pc", pc[0], 64'h0);

    for (int i = 0; i < 600; i++) begin
      rstn  = ($urandom_range(63) != 0);
      trap  = ($urandom_range(9) == 0);
      misp  = ($urandom_range(7) == 0);
      bpv   = $urandom_range(1);
      bpt   = $urandom_range(1);
      ready = ($urandom_range(3) != 0);
      trap_addr = {$urandom, $urandom};
      rec_addr  = ($urandom_range(3) == 0) ?
                  64'hFFFF_FFFF_FFFF_FFF8 : {$urandom, $urandom};
      bp_addr   = {$urandom, $urandom};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
